// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int CYCLES_DEFAULT = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-subtract divide.
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] operand,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
        rem_sh = {acc_hi, acc_lo[31]};
        // remainder stays below the divisor, so diff[32] is exactly the borrow
        diff   = rem_sh - {1'b0, operand};
        if (is_div) begin
            next_hi = diff[32] ? rem_sh[31:0] : diff[31:0];
            next_lo = {acc_lo[30:0], ~diff[32]};
        end else begin
            next_hi = sum[32:1];
            next_lo = {sum[0], acc_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: IDLE -> RUN (CYCLES steps) -> FIX (correct, write).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int CYCLES = CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    input  logic        hilo_read,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  op_q;
    logic [31:0] rs_q, rt_q;
    logic [31:0] w_hi, w_lo, operand_q;
    logic [CW-1:0] cnt;
    logic        fix_phase;
    logic [31:0] step_hi, step_lo;
    logic        is_div, is_signed, sign_diff;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign sign_diff = is_signed & (rs_q[31] ^ rt_q[31]);

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hilo_read | mthi | mtlo);

    muldiv_step u_step (
        .is_div  (is_div),
        .acc_hi  (w_hi),
        .acc_lo  (w_lo),
        .operand (operand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = FIX;
            FIX:     if (fix_phase) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            op_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            w_hi      <= '0;
            w_lo      <= '0;
            operand_q <= '0;
            cnt       <= '0;
            fix_phase <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        rs_q      <= rs_val;
                        rt_q      <= rt_val;
                        cnt       <= '0;
                        fix_phase <= 1'b0;
                        w_hi      <= '0;
                        // multiplier / dividend sits in the low accumulator
                        w_lo      <= op[1] ? abs32(rs_val, ~op[0]) : abs32(rt_val, ~op[0]);
                        operand_q <= op[1] ? abs32(rt_val, ~op[0]) : abs32(rs_val, ~op[0]);
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                RUN: begin
                    w_hi <= step_hi;
                    w_lo <= step_lo;
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    if (!fix_phase) begin
                        fix_phase <= 1'b1;
                        if (!is_div) begin
                            if (sign_diff) {w_hi, w_lo} <= -{w_hi, w_lo};
                        end else if (rt_q == 32'd0) begin
                            w_hi <= rs_q;
                            w_lo <= '1;
                        end else begin
                            if (sign_diff) w_lo <= -w_lo;
                            if (is_signed && rs_q[31]) w_hi <= -w_hi;
                        end
                    end else begin
                        hi   <= w_hi;
                        lo   <= w_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops, stalls, moves, reset abort.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0, mt_data = '0;
    logic        mthi = 1'b0, mtlo = 1'b0, hilo_read = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    muldiv_sequencer #(.CYCLES(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .mt_data   (mt_data),
        .hilo_read (hilo_read),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every done pulse
    exp_t e;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (prev_done) check("done_width", 64'(done), 64'd0);
        prev_done = done;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_spurious: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_lat"}, 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input string name, input bit expect_result);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        if (expect_result) sb.push_back('{hi: eh, lo: el, at: cyc + LAT, name: name});
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, sb.size());
        sb.delete();
    endtask

    initial begin
        // reset state, with start held to show stall stays low while idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        start = 1'b0;
        reset = 1'b0;

        @(negedge clk);
        mthi = 1'b1;
        mt_data = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), 64'd0);

        mthi = 1'b1;
        mtlo = 1'b1;
        mt_data = 32'hABCD;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mtboth_hi", 64'(hi), 64'hABCD);
        check("mtboth_lo", 64'(lo), 64'hABCD);

        // MULT -2*3 with hold and ignored mtlo mid-run
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_m2x3", 1'b1);
        repeat (4) @(negedge clk);
        check("run_hold_hi", 64'(hi), 64'hABCD);
        check("run_hold_lo", 64'(lo), 64'hABCD);
        mtlo = 1'b1;
        mt_data = 32'h5555;
        #1;
        check("run_mtlo_stall", 64'(stall), 64'd1);
        @(negedge clk);
        mtlo = 1'b0;
        check("run_mtlo_ignored", 64'(lo), 64'hABCD);
        wait_idle("mult_m2x3");

        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF});
        vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
        vecs.push_back('{OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2});
        vecs.push_back('{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000});
        vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999});
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
                  $sformatf("vec%0d", i), 1'b1);
            wait_idle($sformatf("vec%0d", i));
        end

        // start with moves: start wins, HI/LO untouched
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs_val = 32'd7; rt_val = 32'd6;
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEAD;
        @(posedge clk);
        #1;
        sb.push_back('{hi: 32'd0, lo: 32'd42, at: cyc + LAT, name: "multu_7x6"});
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_mv_hi", 64'(hi), 64'd5);
        check("start_mv_lo", 64'(lo), 64'h19999999);

        // hilo_read + second start at cycle 5: held until busy falls
        repeat (4) @(negedge clk);
        hilo_read = 1'b1;
        start = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        begin
            bit freed = 1'b0;
            for (int i = 0; i < 60 && !freed; i++) begin
                #1;
                if (busy) begin
                    check("stall_hold", 64'(stall), 64'd1);
                    @(negedge clk);
                end else begin
                    freed = 1'b1;
                end
            end
            if (!freed) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: got busy=1 expected release");
            end
        end
        check("stall_release", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        sb.push_back('{hi: 32'd2, lo: 32'd14, at: cyc + LAT, name: "divu_100_7"});
        @(negedge clk);
        start = 1'b0;
        hilo_read = 1'b0;
        check("second_busy", 64'(busy), 64'd1);
        wait_idle("divu_100_7");

        // reset at cycle 10 of a DIV: abort, no done
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, "div_abort", 1'b0);
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_hi_after", 64'(hi), 64'd0);

        issue(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3x5", 1'b1);
        wait_idle("multu_3x5");
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
